// File: rtl/bm_rng_ctrl.sv
// Bring-up sequencer and two-requester sample arbiter for a Box-Muller Gaussian RNG.
// Owns the seed registers, the generator reset, and the registered grant path.
module bm_rng_ctrl #(
    parameter int INIT_CYCLES  = 2,
    parameter int WARM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_wr,
    input  logic [2:0]  cfg_addr,
    input  logic [31:0] cfg_data,
    input  logic        start,
    input  logic        stop,
    output logic [31:0] seed_0,
    output logic [31:0] seed_1,
    output logic [31:0] seed_2,
    output logic [31:0] seed_3,
    output logic [31:0] seed_4,
    output logic [31:0] seed_5,
    output logic        rng_reset,
    input  logic        rng_valid,
    input  logic [15:0] rng_x0,
    input  logic [15:0] rng_x1,
    input  logic        req0,
    input  logic        req1,
    output logic        gnt0,
    output logic        gnt1,
    output logic [31:0] sample_out,
    output logic [2:0]  state,
    output logic [15:0] sample_cnt
);

    // state | meaning
    // IDLE  | generator held in reset, seed registers writable
    // INIT  | generator reset held for INIT_CYCLES cycles
    // WARM  | reset released, waiting for first rng_valid (bounded by WARM_TIMEOUT)
    // RUN   | arbitrating samples between requesters 0 and 1
    // ERR   | warm-up timed out; only stop leaves this state
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_WARM = 3'd2,
        S_RUN  = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int WW = (WARM_TIMEOUT > 1) ? $clog2(WARM_TIMEOUT + 1) : 1;
    localparam logic [IW-1:0] INIT_LOAD = IW'(INIT_CYCLES - 1);
    localparam logic [WW-1:0] WARM_LAST = WW'(WARM_TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [IW-1:0] init_cnt_q;
    logic [WW-1:0] warm_cnt_q;
    logic          last_q;
    logic          gnt0_q, gnt1_q;
    logic [31:0]   sample_q;
    logic [15:0]   cnt_q;
    logic [31:0]   seed_q [6];
    logic          dec_en;
    logic          pick0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_INIT;
            S_INIT: if (init_cnt_q == '0) state_d = S_WARM;
            S_WARM: begin
                if (rng_valid)
                    state_d = S_RUN;
                else if (warm_cnt_q == WARM_LAST)
                    state_d = S_ERR;
            end
            S_RUN:   state_d = S_RUN;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
        if (stop)
            state_d = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // INIT length as a down-counter reloaded whenever the FSM is outside INIT.
    always_ff @(posedge clk) begin
        if (reset)
            init_cnt_q <= INIT_LOAD;
        else if (state_q != S_INIT)
            init_cnt_q <= INIT_LOAD;
        else if (init_cnt_q != '0)
            init_cnt_q <= init_cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            warm_cnt_q <= '0;
        else if (state_q == S_WARM)
            warm_cnt_q <= warm_cnt_q + 1'b1;
        else
            warm_cnt_q <= '0;
    end

    // Decision cycle: a pending stop cancels it so nothing is granted after leaving RUN.
    assign dec_en = (state_q == S_RUN) && rng_valid && !stop && (req0 || req1);
    assign pick0  = req0 && (!req1 || last_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            last_q   <= 1'b1;
            sample_q <= '0;
        end else begin
            gnt0_q <= dec_en && pick0;
            gnt1_q <= dec_en && !pick0;
            if (dec_en) begin
                last_q   <= !pick0;
                sample_q <= {rng_x0, rng_x1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else if (state_q == S_IDLE && state_d == S_INIT)
            cnt_q <= '0;
        else if (dec_en && cnt_q != 16'hFFFF)
            cnt_q <= cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 6; i++)
                seed_q[i] <= 32'hFFFF_FFFF;
        end else if (cfg_wr && state_q == S_IDLE) begin
            for (int i = 0; i < 6; i++)
                if (cfg_addr == 3'(i))
                    seed_q[i] <= cfg_data;
        end
    end

    assign seed_0     = seed_q[0];
    assign seed_1     = seed_q[1];
    assign seed_2     = seed_q[2];
    assign seed_3     = seed_q[3];
    assign seed_4     = seed_q[4];
    assign seed_5     = seed_q[5];
    assign rng_reset  = (state_q == S_IDLE) || (state_q == S_INIT) || (state_q == S_ERR);
    assign gnt0       = gnt0_q;
    assign gnt1       = gnt1_q;
    assign sample_out = sample_q;
    assign state      = state_q;
    assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_bm_rng_ctrl.sv
// Directed bench for bm_rng_ctrl: bring-up, config lockout, arbitration, timeout,
// stop/start collision, counter saturation and mid-run reset.
module tb_bm_rng_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cfg_wr = 1'b0;
    logic [2:0]  cfg_addr = 3'd0;
    logic [31:0] cfg_data = 32'd0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] seed_0, seed_1, seed_2, seed_3, seed_4, seed_5;
    logic        rng_reset;
    logic        rng_valid = 1'b0;
    logic [15:0] rng_x0 = 16'd0;
    logic [15:0] rng_x1 = 16'd0;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic        gnt0, gnt1;
    logic [31:0] sample_out;
    logic [2:0]  state;
    logic [15:0] sample_cnt;

    int errors = 0;
    int checks = 0;

    localparam logic [2:0] IDLE = 3'd0, INIT = 3'd1, WARM = 3'd2, RUN = 3'd3, ERR = 3'd4;

    bm_rng_ctrl dut (
        .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .start(start), .stop(stop),
        .seed_0(seed_0), .seed_1(seed_1), .seed_2(seed_2), .seed_3(seed_3),
        .seed_4(seed_4), .seed_5(seed_5),
        .rng_reset(rng_reset), .rng_valid(rng_valid), .rng_x0(rng_x0), .rng_x1(rng_x1),
        .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
        .sample_out(sample_out), .state(state), .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (state !== IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", state, IDLE); end
        checks++; if (rng_reset !== 1'b1) begin errors++; $display("FAIL reset_rng_reset got %b exp 1", rng_reset); end
        checks++; if ({gnt0, gnt1} !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b exp 00", {gnt0, gnt1}); end
        checks++; if (sample_out !== 32'd0) begin errors++; $display("FAIL reset_sample_out got %h exp 0", sample_out); end
        checks++; if (sample_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %h exp 0", sample_cnt); end
        checks++;
        if ({seed_0, seed_1, seed_2, seed_3, seed_4, seed_5} !== {6{32'hFFFF_FFFF}}) begin
            errors++;
            $display("FAIL reset_seeds got %h %h %h %h %h %h exp all ffffffff",
                     seed_0, seed_1, seed_2, seed_3, seed_4, seed_5);
        end
    endtask

    task automatic test_seed_bringup();
        cfg_wr = 1'b1; cfg_addr = 3'd2; cfg_data = 32'h1234_5678;
        tick();
        cfg_wr = 1'b0;
        checks++; if (seed_2 !== 32'h1234_5678) begin errors++; $display("FAIL seed2_write got %h exp 12345678", seed_2); end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (state !== INIT || rng_reset !== 1'b1) begin errors++; $display("FAIL init1 got state=%0d rst=%b exp 1/1", state, rng_reset); end
        tick();
        checks++; if (state !== INIT || rng_reset !== 1'b1) begin errors++; $display("FAIL init2 got state=%0d rst=%b exp 1/1", state, rng_reset); end
        tick();
        checks++; if (state !== WARM || rng_reset !== 1'b0) begin errors++; $display("FAIL warm_entry got state=%0d rst=%b exp 2/0", state, rng_reset); end
        for (int i = 0; i < 3; i++) tick();
        checks++; if (state !== WARM) begin errors++; $display("FAIL warm_hold got %0d exp %0d", state, WARM); end
        rng_valid = 1'b1;
        tick();
        checks++; if (state !== RUN || rng_reset !== 1'b0) begin errors++; $display("FAIL run_entry got state=%0d rst=%b exp 3/0", state, rng_reset); end
        checks++; if (seed_2 !== 32'h1234_5678) begin errors++; $display("FAIL seed2_stable got %h exp 12345678", seed_2); end
    endtask

    task automatic test_config_lockout_run();
        cfg_wr = 1'b1; cfg_addr = 3'd0; cfg_data = 32'hDEAD_BEEF;
        tick();
        cfg_wr = 1'b0;
        checks++; if (seed_0 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL lockout_run got %h exp ffffffff", seed_0); end
    endtask

    task automatic test_fairness();
        logic [31:0] exp_sample;
        req0 = 1'b1; req1 = 1'b1; rng_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rng_x0 = 16'hA000 + 16'(i);
            rng_x1 = 16'h0B00 + 16'(i * 3);
            exp_sample = {rng_x0, rng_x1};
            tick();
            checks++;
            if (gnt0 !== (i % 2 == 0) || gnt1 !== (i % 2 == 1)) begin
                errors++; $display("FAIL fair_gnt%0d got %b%b exp %b%b", i, gnt0, gnt1, i % 2 == 0, i % 2 == 1);
            end
            checks++; if (sample_out !== exp_sample) begin errors++; $display("FAIL fair_sample%0d got %h exp %h", i, sample_out, exp_sample); end
        end
        req0 = 1'b0; req1 = 1'b0;
        rng_x0 = 16'h1111; rng_x1 = 16'h2222;
        tick();
        checks++; if (sample_cnt !== 16'd6) begin errors++; $display("FAIL fair_cnt got %0d exp 6", sample_cnt); end
        checks++; if ({gnt0, gnt1} !== 2'b00 || sample_out !== exp_sample) begin errors++; $display("FAIL idle_hold got gnt=%b%b sample=%h exp 00 %h", gnt0, gnt1, sample_out, exp_sample); end
    endtask

    task automatic test_single_and_stall();
        req1 = 1'b1;
        tick();
        checks++; if ({gnt0, gnt1} !== 2'b01) begin errors++; $display("FAIL single_req1 got %b%b exp 01", gnt0, gnt1); end
        req1 = 1'b0; req0 = 1'b1;
        tick();
        checks++; if ({gnt0, gnt1} !== 2'b10) begin errors++; $display("FAIL single_req0 got %b%b exp 10", gnt0, gnt1); end
        req1 = 1'b1; rng_valid = 1'b0;
        tick();
        checks++; if ({gnt0, gnt1} !== 2'b00 || sample_cnt !== 16'd8) begin errors++; $display("FAIL stall got gnt=%b%b cnt=%0d exp 00 8", gnt0, gnt1, sample_cnt); end
        rng_valid = 1'b1;
        tick();
        checks++; if ({gnt0, gnt1} !== 2'b01 || sample_cnt !== 16'd9) begin errors++; $display("FAIL tie_after_stall got gnt=%b%b cnt=%0d exp 01 9", gnt0, gnt1, sample_cnt); end
        req0 = 1'b0; req1 = 1'b0;
        tick();
    endtask

    task automatic test_stop_start();
        req0 = 1'b1; stop = 1'b1; start = 1'b1;
        tick();
        stop = 1'b0; start = 1'b0; req0 = 1'b0;
        checks++; if (state !== IDLE || gnt0 !== 1'b0) begin errors++; $display("FAIL stop_start got state=%0d gnt0=%b exp 0/0", state, gnt0); end
        checks++; if (sample_cnt !== 16'd9) begin errors++; $display("FAIL cnt_after_stop got %0d exp 9", sample_cnt); end
        cfg_wr = 1'b1; cfg_addr = 3'd7; cfg_data = 32'h5555_AAAA;
        tick();
        cfg_wr = 1'b0;
        checks++;
        if ({seed_0, seed_1, seed_2, seed_3, seed_4, seed_5} !==
            {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF}) begin
            errors++;
            $display("FAIL addr7_ignored got %h %h %h %h %h %h", seed_0, seed_1, seed_2, seed_3, seed_4, seed_5);
        end
    endtask

    task automatic test_timeout();
        rng_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (state !== INIT || sample_cnt !== 16'd0) begin errors++; $display("FAIL start_clears got state=%0d cnt=%0d exp 1 0", state, sample_cnt); end
        for (int i = 0; i < 16; i++) tick();
        checks++; if (state !== WARM) begin errors++; $display("FAIL warm_15th got %0d exp %0d", state, WARM); end
        tick();
        checks++; if (state !== ERR || rng_reset !== 1'b1) begin errors++; $display("FAIL timeout got state=%0d rst=%b exp 4/1", state, rng_reset); end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (state !== ERR) begin errors++; $display("FAIL err_start got %0d exp %0d", state, ERR); end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++; if (state !== IDLE) begin errors++; $display("FAIL err_stop got %0d exp %0d", state, IDLE); end
    endtask

    task automatic test_saturation_and_reset();
        int n;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rng_valid = 1'b1;
        tick();
        checks++; if (state !== RUN) begin errors++; $display("FAIL sat_run got %0d exp %0d", state, RUN); end
        req0 = 1'b1;
        n = 0;
        while (sample_cnt !== 16'hFFFE && n < 70000) begin
            tick();
            n++;
        end
        checks++; if (sample_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_preload got %h exp fffe (timeout)", sample_cnt); end
        tick();
        checks++; if (sample_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_first got %h exp ffff", sample_cnt); end
        tick();
        tick();
        checks++; if (sample_cnt !== 16'hFFFF || gnt0 !== 1'b1) begin errors++; $display("FAIL sat_hold got cnt=%h gnt0=%b exp ffff 1", sample_cnt, gnt0); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req0 = 1'b0;
        checks++; if (state !== IDLE || rng_reset !== 1'b1) begin errors++; $display("FAIL mid_reset_state got state=%0d rst=%b exp 0/1", state, rng_reset); end
        checks++; if ({gnt0, gnt1} !== 2'b00 || sample_out !== 32'd0 || sample_cnt !== 16'd0) begin
            errors++; $display("FAIL mid_reset_out got gnt=%b%b sample=%h cnt=%h exp 00 0 0", gnt0, gnt1, sample_out, sample_cnt);
        end
        checks++; if (seed_2 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mid_reset_seed got %h exp ffffffff", seed_2); end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        req0 = 1'b1; req1 = 1'b1;
        tick();
        req0 = 1'b0; req1 = 1'b0;
        checks++; if ({gnt0, gnt1} !== 2'b10) begin errors++; $display("FAIL ptr_after_reset got %b%b exp 10", gnt0, gnt1); end
    endtask

    initial begin
        test_reset();
        test_seed_bringup();
        test_config_lockout_run();
        test_fairness();
        test_single_and_stall();
        test_stop_start();
        test_timeout();
        test_saturation_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
